ahblite_gpio_slave: RTL and testbench

AHB-Lite slave for the GPIO0 peripheral window 0x40000020–0x4000002F. It is driven by the decoder's GPIO0 select (P2_HSEL) and returns its response through the slave multiplexer. The block holds the output-data and output-enable registers, synchronises the input pins, and raises a level interrupt on rising edges of pins configured as inputs.

---
 rtl/ahblite_gpio_slave_pkg.sv | 20 ++
 rtl/ahblite_gpio_slave_gpio_in_sync.sv | 32 +++
 rtl/ahblite_gpio_slave.sv | 122 ++++++++++++
 tb/tb_ahblite_gpio_slave.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ahblite_gpio_slave_pkg.sv
// Shared constants for the GPIO0 AHB-Lite slave: register offsets and window base.
package ahblite_gpio_slave_pkg;

  // Word offsets within the GPIO0 window (HADDR[3:2]).
  typedef enum logic [1:0] {
    REG_OUT_DATA = 2'd0,
    REG_IN_DATA  = 2'd1,
    REG_OUT_EN   = 2'd2,
    REG_INT_STAT = 2'd3
  } gpio_reg_e;

  // GPIO0 peripheral window base, shared with the decoder and software headers.
  localparam logic [31:0] GPIO0_BASE = 32'h4000_0020;

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahblite_gpio_slave_gpio_in_sync.sv
// Two-flop input synchroniser followed by a rising-edge detector.
module gpio_in_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync2_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;

  // Synchroniser chain plus one-cycle delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sync2_o = sync2_q;
  assign edge_o  = sync2_q & ~prev_q;

endmodule

// File: rtl/ahblite_gpio_slave.sv
// AHB-Lite slave for GPIO0: output data/enable registers, synchronised inputs,
// and a level interrupt on rising edges of pins configured as inputs.
module ahblite_gpio_slave
  import ahblite_gpio_slave_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  input  logic [GPIO_WIDTH-1:0] GPIO_IN,
  output logic [GPIO_WIDTH-1:0] GPIO_OUT,
  output logic [GPIO_WIDTH-1:0] GPIO_OE,
  output logic                  GPIO_IRQ
);

  logic                  accept;
  logic                  valid_q, valid_d;
  logic                  wr_q, wr_d;
  gpio_reg_e             addr_q, addr_d;

  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] oe_q, oe_d;
  logic [GPIO_WIDTH-1:0] int_q, int_d;
  logic [GPIO_WIDTH-1:0] clr;
  logic [GPIO_WIDTH-1:0] in_sync;
  logic [GPIO_WIDTH-1:0] in_edge;
  logic [31:0]           rdata;

  // Only HADDR[3:2], HTRANS[1] and the low GPIO_WIDTH bits of HWDATA matter.
  logic unused_bus;
  assign unused_bus = ^{HSIZE, HPROT, HADDR, HTRANS[0], HWDATA};

  gpio_in_sync #(
    .WIDTH (GPIO_WIDTH)
  ) u_in_sync (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .pin_i   (GPIO_IN),
    .sync2_o (in_sync),
    .edge_o  (in_edge)
  );

  // Address-phase capture: remember direction and register for the data phase.
  always_comb begin
    accept  = HSEL & HREADY & htrans_active(HTRANS);
    valid_d = accept;
    wr_d    = wr_q;
    addr_d  = addr_q;
    if (accept) begin
      wr_d   = HWRITE;
      addr_d = gpio_reg_e'(HADDR[3:2]);
    end
  end

  // Data-phase writes and interrupt status update; a set beats a same-cycle clear.
  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    clr   = '0;
    if (valid_q && wr_q) begin
      case (addr_q)
        REG_OUT_DATA: out_d = HWDATA[GPIO_WIDTH-1:0];
        REG_OUT_EN:   oe_d  = HWDATA[GPIO_WIDTH-1:0];
        REG_INT_STAT: clr   = HWDATA[GPIO_WIDTH-1:0];
        default:      ;
      endcase
    end
    int_d = (int_q & ~clr) | (in_edge & ~oe_q);
  end

  // Bus pipeline and register state; reset abandons any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= REG_OUT_DATA;
      out_q   <= '0;
      oe_q    <= '0;
      int_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      int_q   <= int_d;
    end
  end

  // Read mux: only drives data during a read data phase, zero otherwise.
  always_comb begin
    rdata = '0;
    if (valid_q && !wr_q) begin
      case (addr_q)
        REG_OUT_DATA: rdata[GPIO_WIDTH-1:0] = out_q;
        REG_IN_DATA:  rdata[GPIO_WIDTH-1:0] = in_sync;
        REG_OUT_EN:   rdata[GPIO_WIDTH-1:0] = oe_q;
        REG_INT_STAT: rdata[GPIO_WIDTH-1:0] = int_q;
        default:      ;
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign GPIO_OUT  = out_q;
  assign GPIO_OE   = oe_q;
  assign GPIO_IRQ  = |int_q;

endmodule

// File: tb/tb_ahblite_gpio_slave.sv
// Self-checking bench for ahblite_gpio_slave: table of pipelined transfers with a
// read-data scoreboard, plus hand-written interrupt and reset sequences.
module tb_ahblite_gpio_slave;

  localparam logic [31:0] BASE = 32'h4000_0020;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [7:0]  GPIO_IN;
  logic [7:0]  GPIO_OUT;
  logic [7:0]  GPIO_OE;
  logic        GPIO_IRQ;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] exp_q[$];
  bit          rd_pending = 1'b0;
  logic [31:0] nxt_wdata  = '0;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  always #5 HCLK = ~HCLK;

  ahblite_gpio_slave #(
    .GPIO_WIDTH (8)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HPROT     (HPROT),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .GPIO_IN   (GPIO_IN),
    .GPIO_OUT  (GPIO_OUT),
    .GPIO_OE   (GPIO_OE),
    .GPIO_IRQ  (GPIO_IRQ)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle, entered just after a rising edge: drives the address phase of
  // this transfer and the write data of the previous one, then checks the data
  // phase of the previous transfer at the falling edge.
  task automatic bus(input bit sel, input logic [1:0] trans, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp);
    bit          acc;
    logic [31:0] e;
    HWDATA = nxt_wdata;
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    acc    = sel && trans[1];
    if (acc && !wr) exp_q.push_back(exp);
    @(negedge HCLK);
    chk("ready_resp", {31'd0, HREADYOUT, HRESP}, 32'd2);
    if (rd_pending) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", HRDATA, e);
      end
    end
    @(posedge HCLK);
    #1;
    rd_pending = acc && !wr;
    nxt_wdata  = wdata;
  endtask

  task automatic idle();
    bus(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp);
    bus(1'b1, 2'b10, 1'b0, BASE + {28'd0, off}, 32'd0, exp);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] data);
    bus(1'b1, 2'b10, 1'b1, BASE + {28'd0, off}, data, 32'd0);
  endtask

  initial begin
    // Back-to-back transfer table; reads carry their expected data.
    vecs[0]  = '{1'b1, 2'b10, 1'b0, BASE + 32'h4, 32'h00, 32'hFF}; // IN_DATA = pins
    vecs[1]  = '{1'b1, 2'b10, 1'b0, BASE + 32'hC, 32'h00, 32'hFF}; // post-reset edges
    vecs[2]  = '{1'b1, 2'b10, 1'b1, BASE + 32'hC, 32'hFF, 32'h00}; // clear all
    vecs[3]  = '{1'b1, 2'b10, 1'b1, BASE + 32'h0, 32'hA5, 32'h00};
    vecs[4]  = '{1'b1, 2'b10, 1'b1, BASE + 32'h8, 32'hF0, 32'h00};
    vecs[5]  = '{1'b1, 2'b10, 1'b0, BASE + 32'h0, 32'h00, 32'hA5};
    vecs[6]  = '{1'b1, 2'b10, 1'b0, BASE + 32'h8, 32'h00, 32'hF0};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, BASE + 32'hC, 32'h00, 32'h00};
    vecs[8]  = '{1'b1, 2'b10, 1'b1, BASE + 32'h4, 32'h55, 32'h00}; // RO, ignored
    vecs[9]  = '{1'b1, 2'b10, 1'b0, BASE + 32'h4, 32'h00, 32'hFF};
    vecs[10] = '{1'b1, 2'b00, 1'b1, BASE + 32'h0, 32'h55, 32'h00}; // IDLE write
    vecs[11] = '{1'b0, 2'b10, 1'b1, BASE + 32'h0, 32'h66, 32'h00}; // not selected
    vecs[12] = '{1'b1, 2'b10, 1'b0, BASE + 32'h0, 32'h00, 32'hA5};
    vecs[13] = '{1'b1, 2'b11, 1'b0, BASE + 32'h8, 32'h00, 32'hF0}; // SEQ read

    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HADDR   = '0;
    HTRANS  = 2'b00;
    HSIZE   = 3'b010;
    HPROT   = 4'b0011;
    HWRITE  = 1'b0;
    HWDATA  = '0;
    HREADY  = 1'b1;
    GPIO_IN = 8'hFF;

    // Reset state.
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_out", {24'd0, GPIO_OUT}, 32'h00);
    chk("rst_oe", {24'd0, GPIO_OE}, 32'h00);
    chk("rst_irq", {31'd0, GPIO_IRQ}, 32'd0);
    chk("rst_rdata", HRDATA, 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (4) idle();

    foreach (vecs[i])
      bus(vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    idle();
    chk("tbl_out", {24'd0, GPIO_OUT}, 32'hA5);
    chk("tbl_oe", {24'd0, GPIO_OE}, 32'hF0);
    chk("tbl_irq", {31'd0, GPIO_IRQ}, 32'd0);

    // Rising edge on pins 0 and 4; pin 4 is an output so only bit 0 records.
    GPIO_IN = 8'h00;
    repeat (4) idle();
    GPIO_IN = 8'h11;
    idle();
    idle();
    chk("irq_edge2", {31'd0, GPIO_IRQ}, 32'd0);
    idle();
    chk("irq_edge3", {31'd0, GPIO_IRQ}, 32'd1);
    rd(4'hC, 32'h01);
    wr(4'hC, 32'h01);
    idle();
    chk("irq_cleared", {31'd0, GPIO_IRQ}, 32'd0);
    rd(4'hC, 32'h00);

    // W1C of bit 0 lands on the same edge that records a new rising edge on pin 0.
    GPIO_IN = 8'h10;
    repeat (4) idle();
    GPIO_IN = 8'h11;
    idle();
    wr(4'hC, 32'h01);
    idle();
    chk("collide_irq", {31'd0, GPIO_IRQ}, 32'd1);
    rd(4'hC, 32'h01);
    wr(4'hC, 32'h01);
    idle();
    chk("collide_clr", {31'd0, GPIO_IRQ}, 32'd0);

    // Reset during the data phase of a write abandons it.
    wr(4'h0, 32'h3C);
    HWDATA = nxt_wdata;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    #2;
    HRESETn = 1'b0;
    @(negedge HCLK);
    chk("midrst_out", {24'd0, GPIO_OUT}, 32'h00);
    chk("midrst_oe", {24'd0, GPIO_OE}, 32'h00);
    @(posedge HCLK);
    #1;
    HRESETn    = 1'b1;
    rd_pending = 1'b0;
    nxt_wdata  = '0;
    idle();
    chk("postrst_out", {24'd0, GPIO_OUT}, 32'h00);
    rd(4'h0, 32'h00);
    idle();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
